div_issue_ctrl: RTL and testbench
=================================

// Module: div_issue_ctrl
// PURPOSE
//  Initiator side of the multi-cycle unsigned divider interface. Sits in the EX stage: accepts DIV/DIVU/REM/REMU,
//  converts signed operands to magnitudes, pulses the divider, waits out its busy window, sign-corrects the result
//  and holds the pipeline via stallreq. Resolves divide-by-zero and signed overflow locally without using the divider.
// PARAMETERS
//  XLEN  32  operand/result width; the divider datapath matches it.
// PORTS
//  clk           in   1     clock
//  rst_n         in   1     synchronous, active-low reset
//  flush         in   1     cancel the in-flight op (branch/trap)
//  op_valid      in   1     EX holds a divide op; held stable while stallreq=1
//  op            in   2     bit1=REM(1)/DIV(0), bit0=unsigned(1)/signed(0)
//  rs1, rs2      in   XLEN  dividend, divisor
//  stallreq      out  1     freeze pipeline
//  res_valid     out  1     one-cycle result strobe
//  result        out  XLEN  quotient or remainder
//  dv_in_valid   out  1     divider load pulse
//  dv_a, dv_b    out  XLEN  unsigned dividend/divisor magnitudes
//  dv_stallreq   in   1     divider busy (in_valid | count!=0)
//  dv_quotient   in   XLEN  divider quotient
//  dv_remainder  in   XLEN  divider remainder
// BEHAVIOUR
//  Reset: state=IDLE; stallreq, res_valid, dv_in_valid, result, dv_a, dv_b all 0.
//  FSM: IDLE, ISSUE, WAIT, DONE, DRAIN.
//   IDLE : op_valid & ~flush -> accept; latch op, signs, magnitudes. Special case -> DONE, else ISSUE.
//   ISSUE: dv_in_valid=1 exactly this cycle -> WAIT. Never asserted in any other state.
//   WAIT : on ~dv_stallreq, capture dv_quotient/dv_remainder, sign-fix into result -> DONE.
//   DONE : res_valid=1, stallreq=0 -> IDLE. The same op_valid here is never re-accepted.
//   DRAIN: entered on flush in ISSUE/WAIT; wait for ~dv_stallreq -> IDLE. No res_valid.
//  stallreq = (IDLE & op_valid & ~flush) | ISSUE | WAIT | DRAIN.
//  Latency, accept cycle T0: divider path DONE at T35; special case DONE at T1.
//  Sign rules (signed ops): q negated iff sign(rs1)!=sign(rs2); r takes sign of rs1. Magnitude of -2^31 = 2^31.
//  Divisor 0: q=all ones, r=rs1; divider not used.
//  DIV/REM with rs1=-2^(XLEN-1), rs2=-1: q=rs1, r=0; divider not used.
//  flush in IDLE or DONE: no effect on state (DONE still completes). Flush wins over op_valid in IDLE.
//  Reset mid-operation: immediate IDLE. The divider is reset by the same rst_n.
// CONFIGURATION
//  DIV_RESULT_CACHE_EN defined:
//   - Keep last {rs1, rs2, signedness, q, r} and a cache-valid bit.
//   - Exact match in IDLE -> DONE at T1 with the cached value, so REM after DIV costs 2 cycles.
//   - Cache-valid is cleared on reset and on flush during DRAIN. Special-case results are not cached.
//  DIV_RESULT_CACHE_EN undefined: no cache storage; every non-special op goes through ISSUE.
// STRUCTURE
//  Package mext_pkg: op encodings (OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11) and state encodings.
//  Sub-module div_sign_fix: combinational abs/negate for operand prep and result correction.
//  The divider itself is a sibling instance, not instantiated inside this block.
// TESTING
//  DIV 100/7          -> res_valid at T35, result=14; single dv_in_valid pulse at T1.
//  REM -7/2           -> result=-1 (0xFFFFFFFF); DIV -7/2 -> result=-3.
//  DIVU 5/0           -> T1 result=0xFFFFFFFF; REMU 5/0 -> result=5; dv_in_valid never 1.
//  DIV 0x80000000/-1  -> T1 result=0x80000000; REM -> 0.
//  flush at T10 of DIVU -> DRAIN; stallreq stays 1 until divider idle; no res_valid; next op computes correctly.
//  CACHE_EN: DIV 100/7 then REM 100/7 -> second op res_valid at T1, result=2. Without CACHE_EN -> T35.

Source files
------------

// File: rtl/mext_pkg.sv
// Shared encodings for the M-extension divide issue logic: opcodes, FSM states
// and small opcode decode helpers.
package mext_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } div_state_e;

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// EX-stage divide request/result signals plus the sideband to the sibling
// multi-cycle divider. master = issue controller, slave = pipeline + divider.
interface div_issue_ctrl_if #(
  parameter int XLEN = 32
);
  // Handshake: the pipeline holds op_valid/op/rs1/rs2 stable while stallreq=1;
  // res_valid is a one-cycle strobe with result; dv_in_valid is a one-cycle load
  // pulse and the divider reports busy on dv_stallreq until its outputs are final.
  logic            flush;
  logic            op_valid;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            stallreq;
  logic            res_valid;
  logic [XLEN-1:0] result;
  logic            dv_in_valid;
  logic [XLEN-1:0] dv_a;
  logic [XLEN-1:0] dv_b;
  logic            dv_stallreq;
  logic [XLEN-1:0] dv_quotient;
  logic [XLEN-1:0] dv_remainder;

  modport master (
    input  flush, op_valid, op, rs1, rs2, dv_stallreq, dv_quotient, dv_remainder,
    output stallreq, res_valid, result, dv_in_valid, dv_a, dv_b
  );

  modport slave (
    output flush, op_valid, op, rs1, rs2, dv_stallreq, dv_quotient, dv_remainder,
    input  stallreq, res_valid, result, dv_in_valid, dv_a, dv_b
  );

endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate: used both to take operand magnitudes
// and to restore the sign of the divider's quotient/remainder.
module div_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] val_i,
  input  logic            neg_i,
  output logic [XLEN-1:0] val_o
);

  assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/div_issue_ctrl.sv
// Divide issue controller: operand prep, divider handshake, sign correction and
// pipeline stall. Optional last-result cache enabled by DIV_RESULT_CACHE_EN.
module div_issue_ctrl
  import mext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  div_issue_ctrl_if.master  bus,
  output div_state_e        state_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic            rem_q, rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] dv_a_q, dv_a_d;
  logic [XLEN-1:0] dv_b_q, dv_b_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            stallreq, res_valid, dv_in_valid;

  logic            is_signed, div0, ovf, special, accept;
  logic [XLEN-1:0] mag_a, mag_b, fix_q, fix_r;
  logic [XLEN-1:0] spec_res;
  logic            cache_hit;
  logic [XLEN-1:0] hit_res;

  assign is_signed = op_is_signed(bus.op);
  assign div0      = (bus.rs2 == '0);
  assign ovf       = is_signed & (bus.rs1 == INT_MIN) & (bus.rs2 == '1);
  assign special   = div0 | ovf;
  assign accept    = (state_q == S_IDLE) & bus.op_valid & ~bus.flush;

  // Divide-by-zero: q=all ones, r=rs1. Overflow: q=rs1, r=0.
  assign spec_res = op_is_rem(bus.op) ? (div0 ? bus.rs1 : '0)
                                      : (div0 ? '1 : bus.rs1);

  div_sign_fix #(.XLEN(XLEN)) u_abs_a (
    .val_i (bus.rs1),
    .neg_i (is_signed & bus.rs1[XLEN-1]),
    .val_o (mag_a)
  );

  div_sign_fix #(.XLEN(XLEN)) u_abs_b (
    .val_i (bus.rs2),
    .neg_i (is_signed & bus.rs2[XLEN-1]),
    .val_o (mag_b)
  );

  div_sign_fix #(.XLEN(XLEN)) u_fix_q (
    .val_i (bus.dv_quotient),
    .neg_i (qneg_q),
    .val_o (fix_q)
  );

  div_sign_fix #(.XLEN(XLEN)) u_fix_r (
    .val_i (bus.dv_remainder),
    .neg_i (rneg_q),
    .val_o (fix_r)
  );

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_vld_q;
  logic            c_sgn_q;
  logic [XLEN-1:0] c_rs1_q, c_rs2_q, c_q_q, c_r_q;
  logic            cache_wr, cache_clr;

  assign cache_hit = cache_vld_q & (bus.rs1 == c_rs1_q) & (bus.rs2 == c_rs2_q) &
                     (is_signed == c_sgn_q);
  assign hit_res   = op_is_rem(bus.op) ? c_r_q : c_q_q;
  assign cache_wr  = (state_q == S_WAIT) & ~bus.flush & ~bus.dv_stallreq;
  assign cache_clr = (state_q == S_DRAIN) & bus.flush;

  // Operands are still on the bus at capture time: the pipeline holds them while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cache_vld_q <= 1'b0;
      c_sgn_q     <= 1'b0;
      c_rs1_q     <= '0;
      c_rs2_q     <= '0;
      c_q_q       <= '0;
      c_r_q       <= '0;
    end else if (cache_clr) begin
      cache_vld_q <= 1'b0;
    end else if (cache_wr) begin
      cache_vld_q <= 1'b1;
      c_sgn_q     <= is_signed;
      c_rs1_q     <= bus.rs1;
      c_rs2_q     <= bus.rs2;
      c_q_q       <= fix_q;
      c_r_q       <= fix_r;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_res   = '0;
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dv_a_d      = dv_a_q;
    dv_b_d      = dv_b_q;
    result_d    = result_q;
    stallreq    = 1'b0;
    res_valid   = 1'b0;
    dv_in_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          stallreq = 1'b1;
          rem_d    = op_is_rem(bus.op);
          qneg_d   = is_signed & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
          rneg_d   = is_signed & bus.rs1[XLEN-1];
          dv_a_d   = mag_a;
          dv_b_d   = mag_b;
          if (special) begin
            result_d = spec_res;
            state_d  = S_DONE;
          end else if (cache_hit) begin
            result_d = hit_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        stallreq    = 1'b1;
        dv_in_valid = 1'b1;
        state_d     = bus.flush ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stallreq = 1'b1;
        if (bus.flush) begin
          state_d = S_DRAIN;
        end else if (!bus.dv_stallreq) begin
          result_d = rem_q ? fix_r : fix_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      S_DRAIN: begin
        // The divider shares no cancel input; wait until it is idle before reuse.
        stallreq = 1'b1;
        if (!bus.dv_stallreq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rem_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dv_a_q   <= '0;
      dv_b_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dv_a_q   <= dv_a_d;
      dv_b_q   <= dv_b_d;
      result_q <= result_d;
    end
  end

  assign bus.stallreq    = stallreq;
  assign bus.res_valid   = res_valid;
  assign bus.result      = result_q;
  assign bus.dv_in_valid = dv_in_valid;
  assign bus.dv_a        = dv_a_q;
  assign bus.dv_b        = dv_b_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural 32-cycle divider, arithmetic result
// model with a latency/stall timeline, directed literal cases and random ops.
module tb_div_issue_ctrl;
  import mext_pkg::*;

  localparam int XLEN = 32;
`ifdef DIV_RESULT_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.XLEN(XLEN)) bus();
  div_state_e state;

  div_issue_ctrl #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- divider model: busy 32 cycles after the load pulse ----------------
  logic [5:0]      dv_cnt;
  logic [XLEN-1:0] dv_al, dv_bl, junk;

  always @(posedge clk) begin
    junk <= $urandom;
    if (!rst_n) begin
      dv_cnt <= '0;
      dv_al  <= '0;
      dv_bl  <= '0;
    end else if (bus.dv_in_valid) begin
      dv_cnt <= 6'd32;
      dv_al  <= bus.dv_a;
      dv_bl  <= bus.dv_b;
    end else if (dv_cnt != 0) begin
      dv_cnt <= dv_cnt - 6'd1;
    end
  end

  assign bus.dv_stallreq  = bus.dv_in_valid | (dv_cnt != 0);
  assign bus.dv_quotient  = (dv_cnt != 0) ? junk : ((dv_bl == 0) ? '1 : dv_al / dv_bl);
  assign bus.dv_remainder = (dv_cnt != 0) ? ~junk : ((dv_bl == 0) ? dv_al : dv_al % dv_bl);

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];

  bit              m_check = 1'b0;
  bit              m_active = 1'b0;
  bit              m_issue = 1'b0;
  int              m_t = 0;
  int              m_lat = 0;
  int              m_stall_end = 0;
  logic [XLEN-1:0] m_a_mag, m_b_mag;
  int              obs_lat = -1;
  int              obs_issues = 0;

  bit              c_vld = 1'b0;
  bit              c_sgn = 1'b0;
  logic [XLEN-1:0] c_a, c_b;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] model_res(input logic [1:0] o, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [XLEN-1:0] q, r;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = '0;
    end else if (!o[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction

  // ---------------- compare process ----------------
  logic e_st, e_rv, e_iv;
  always @(negedge clk) begin
    if (m_check) begin
      if (m_active) begin
        e_st = (m_t <= m_stall_end);
        e_rv = (m_lat >= 0) && (m_t == m_lat);
        e_iv = m_issue && (m_t == 1);
      end else begin
        e_st = 1'b0;
        e_rv = 1'b0;
        e_iv = 1'b0;
      end
      chk("stallreq", 32'(bus.stallreq), 32'(e_st));
      chk("res_valid", 32'(bus.res_valid), 32'(e_rv));
      chk("dv_in_valid", 32'(bus.dv_in_valid), 32'(e_iv));
      if (bus.res_valid) begin
        obs_lat = m_t;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got %h with no result pending", bus.result);
        end else begin
          chk("result", bus.result, exp_q.pop_front());
        end
      end
      if (bus.dv_in_valid) begin
        obs_issues++;
        if (e_iv) begin
          chk("dv_a", bus.dv_a, m_a_mag);
          chk("dv_b", bus.dv_b, m_b_mag);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // fl = cycle (relative to accept) at which flush pulses; -1 for none.
  task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input int fl);
    bit sgn, special, hit, flushed;
    int last;
    sgn     = ~o[0];
    special = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit     = CACHE_EN && c_vld && c_a == a && c_b == b && c_sgn == sgn && !special;
    m_lat   = (special || hit) ? 1 : 35;
    m_issue = !(special || hit);
    m_a_mag = (sgn && a[XLEN-1]) ? -a : a;
    m_b_mag = (sgn && b[XLEN-1]) ? -b : b;
    flushed = (fl >= 1) && (fl < m_lat);
    if (flushed) begin
      m_stall_end = (fl + 1 > 34) ? fl + 1 : 34;
      last        = m_stall_end + 1;
      m_lat       = -1;
    end else begin
      m_stall_end = m_lat - 1;
      last        = m_lat;
      exp_q.push_back(model_res(o, a, b));
      if (m_issue) begin
        c_vld = 1'b1;
        c_a   = a;
        c_b   = b;
        c_sgn = sgn;
      end
    end
    obs_lat      = -1;
    obs_issues   = 0;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.rs1      = a;
    bus.rs2      = b;
    m_active     = 1'b1;
    for (int t = 0; t <= last; t++) begin
      m_t       = t;
      bus.flush = (t == fl);
      if (flushed && t > fl) bus.op_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    m_active     = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_a, r_b;
  int              r_fl, r_sel;

  initial begin
    bus.flush    = 1'b0;
    bus.op_valid = 1'b0;
    bus.op       = OP_DIV;
    bus.rs1      = '0;
    bus.rs2      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_stallreq", 32'(bus.stallreq), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_dv_in_valid", 32'(bus.dv_in_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_dv_a", bus.dv_a, 32'd0);
    chk("rst_dv_b", bus.dv_b, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_check = 1'b1;
    @(posedge clk);
    #1;

    // directed cases with hand-computed results
    run_op(OP_DIV, 32'd100, 32'd7, -1);
    chk("div100_7_lat", 32'(obs_lat), 32'd35);
    chk("div100_7_issues", 32'(obs_issues), 32'd1);
    run_op(OP_REM, -32'd7, 32'd2, -1);
    chk("rem_m7_2_lat", 32'(obs_lat), 32'd35);
    run_op(OP_DIV, -32'd7, 32'd2, -1);
    chk("div_m7_2_issues", 32'(obs_issues), 32'd1);
    run_op(OP_DIVU, 32'd5, 32'd0, -1);
    chk("divu_5_0_lat", 32'(obs_lat), 32'd1);
    chk("divu_5_0_issues", 32'(obs_issues), 32'd0);
    run_op(OP_REMU, 32'd5, 32'd0, 1);
    chk("remu_5_0_lat", 32'(obs_lat), 32'd1);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_ovf_lat", 32'(obs_lat), 32'd1);
    chk("div_ovf_issues", 32'(obs_issues), 32'd0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("rem_ovf_lat", 32'(obs_lat), 32'd1);
    run_op(OP_DIVU, 32'd1000, 32'd3, 10);
    chk("flush_no_result", 32'(obs_lat), 32'hFFFF_FFFF);
    chk("flush_issues", 32'(obs_issues), 32'd1);
    run_op(OP_DIV, 32'd100, 32'd7, -1);
    chk("after_flush_lat", 32'(obs_lat), 32'd35);
    run_op(OP_REM, 32'd100, 32'd7, -1);
    chk("rem_after_div_lat", 32'(obs_lat), CACHE_EN ? 32'd1 : 32'd35);

    // randomized operations
    r_a = 32'd0;
    r_b = 32'd0;
    for (int i = 0; i < 80; i++) begin
      r_op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        r_a = rnd_val();
        r_b = rnd_val();
      end
      r_sel = $urandom_range(0, 9);
      r_fl  = (r_sel == 0) ? $urandom_range(1, 34) : (r_sel == 1) ? 35 : (r_sel == 2) ? 1 : -1;
      run_op(r_op, r_a, r_b, r_fl);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // reset in the middle of a divider op
    m_check      = 1'b0;
    bus.op_valid = 1'b1;
    bus.op       = OP_DIVU;
    bus.rs1      = 32'hDEAD_BEEF;
    bus.rs2      = 32'd9;
    repeat (12) @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", 32'(state), 32'(S_IDLE));
    chk("midrst_stallreq", 32'(bus.stallreq), 32'd0);
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    c_vld   = 1'b0;
    m_check = 1'b1;
    @(posedge clk);
    #1;
    run_op(OP_DIV, 32'd100, 32'd7, -1);
    chk("post_rst_lat", 32'(obs_lat), 32'd35);
    run_op(OP_REM, 32'd100, 32'd7, -1);
    chk("post_rst_rem_lat", 32'(obs_lat), CACHE_EN ? 32'd1 : 32'd35);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
